uiuart_tx_cfg: RTL

Parametrised successor UART transmitter for the video-platform control path.
- Adds a write FIFO with a valid/ready handshake.
- Frame format is selected at run time: divisor, 5–8 data bits, parity mode, 1 or 2 stop bits.
- Back-to-back frames are sent with no idle gap.
- Sits between the command/debug logic and the board TX pin. Replaces the fixed 8N1 single-byte transmitter wherever a queued or configurable link is needed.

---
 rtl/uiuart_tx_cfg.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uiuart_tx_cfg.sv
// uiuart_tx_cfg: queued UART transmitter with a run-time frame format.
// A small write FIFO feeds a START/DATA/PARITY/STOP engine. Every frame
// latches its own copy of the format when its byte is popped. The line is
// registered from the FSM state, so it trails the state by one clock.
module uiuart_tx_cfg #(
    parameter int DIV_W    = 16,
    parameter int FIFO_AW  = 4,
    parameter bit DEF_IDLE = 1'b1
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [DIV_W-1:0]   I_cfg_div,
    input  logic [1:0]         I_cfg_dbits,
    input  logic [1:0]         I_cfg_parity,
    input  logic               I_cfg_stop2,
    input  logic               I_uart_wreq,
    input  logic [7:0]         I_uart_wdata,
    output logic               O_uart_wready,
    output logic               O_uart_wbusy,
    output logic [FIFO_AW:0]   O_fifo_cnt,
    output logic               O_tx_done,
    output logic               O_uart_tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   cnt;
    logic               push, pop, fifo_ne;
    logic [7:0]         head;

    // frame engine
    state_t             state_q, state_d;
    logic [DIV_W-1:0]   baud_q;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic [DIV_W-1:0]   f_div;
    logic [1:0]         f_dbits;
    logic [1:0]         f_parity;
    logic               f_stop2;
    logic               par_bit;
    logic               bnd, done_d, line_bit;
    logic [2:0]         nbits_m1;

    // parity of the byte being popped, using the format latched on the same edge
    logic [7:0]         head_mask;
    logic               head_xor, par_new;

    assign O_uart_wready = (cnt != FULL_CNT);
    assign push          = I_uart_wreq & O_uart_wready;
    assign fifo_ne       = (cnt != '0);
    assign head          = mem[rptr];
    assign O_fifo_cnt    = cnt;
    assign O_uart_wbusy  = fifo_ne | (state_q != S_IDLE);

    assign bnd      = (baud_q == f_div);
    assign nbits_m1 = 3'd4 + {1'b0, f_dbits};

    assign head_mask = 8'hFF >> (2'd3 - I_cfg_dbits);
    assign head_xor  = ^(head & head_mask);

    // parity bit chosen from the incoming format
    always_comb begin
        par_new = 1'b0;
        case (I_cfg_parity)
            2'd1:    par_new = ~head_xor;
            2'd2:    par_new = head_xor;
            2'd3:    par_new = 1'b1;
            default: par_new = 1'b0;
        endcase
    end

    // FIFO storage write; contents need no reset
    always_ff @(posedge I_clk) begin
        if (push) mem[wptr] <= I_uart_wdata;
    end

    // FIFO pointers and occupancy; push+pop together leaves the count unchanged
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // state register
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next state, pop request, line level and end-of-frame strobe
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        done_d   = 1'b0;
        line_bit = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (fifo_ne) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                line_bit = 1'b0;
                if (bnd) state_d = S_DATA;
            end
            S_DATA: begin
                line_bit = shreg[0];
                if (bnd && bit_cnt == nbits_m1)
                    state_d = (f_parity != 2'd0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                line_bit = par_bit;
                if (bnd) state_d = S_STOP;
            end
            S_STOP: begin
                // bit_cnt counts stop bits; the last one is index f_stop2
                if (bnd && (bit_cnt[0] == f_stop2)) begin
                    done_d = 1'b1;
                    if (fifo_ne) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // baud/bit counters, shift register and per-frame format latch
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            baud_q   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            f_div    <= '0;
            f_dbits  <= '0;
            f_parity <= '0;
            f_stop2  <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            if (state_d != state_q || state_q == S_IDLE) begin
                baud_q  <= '0;
                bit_cnt <= '0;
            end else if (bnd) begin
                baud_q  <= '0;
                bit_cnt <= bit_cnt + 3'd1;
            end else begin
                baud_q  <= baud_q + 1'b1;
            end

            if (pop) begin
                shreg    <= head;
                f_div    <= I_cfg_div;
                f_dbits  <= I_cfg_dbits;
                f_parity <= I_cfg_parity;
                f_stop2  <= I_cfg_stop2;
                par_bit  <= par_new;
            end else if (state_q == S_DATA && bnd) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end

    // registered line and done strobe; idle level follows DEF_IDLE
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_uart_tx <= DEF_IDLE;
            O_tx_done <= 1'b0;
        end else begin
            O_uart_tx <= line_bit ^ ~DEF_IDLE;
            O_tx_done <= done_d;
        end
    end

endmodule
